cut_position_keygen: RTL and testbench

Keystream source for the line-rotation scrambler. A 32-bit Galois LFSR is reseeded from a programmable key at the start of every field's active video, then advanced eight steps per active line. It presents a stable 8-bit cut position to the line rotator's `raw_cut_position` input. It sits between the BT.656 `sync_parser` (H/V/F) and `line_rotator`; the descrambler side instantiates the identical block so both ends regenerate the same sequence.

---
 rtl/cut_position_keygen_if.sv | 23 ++
 rtl/cut_position_keygen.sv | 136 +++++++++++++
 tb/tb_cut_position_keygen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cut_position_keygen_if.sv
// Signal bundle between the sync parser / key source and the cut position
// key generator. The master drives timing and key, the slave returns the
// cut position stream.
interface cut_position_keygen_if;
    logic        H;
    logic        V;
    logic        F;
    logic [31:0] seed_in;
    logic        seed_load;
    logic [7:0]  cut_position;
    logic        cut_valid;
    logic        busy;

    modport master (
        output H, V, F, seed_in, seed_load,
        input  cut_position, cut_valid, busy
    );

    modport slave (
        input  H, V, F, seed_in, seed_load,
        output cut_position, cut_valid, busy
    );
endinterface

// File: rtl/cut_position_keygen.sv
// Cut position keystream for the line-rotation scrambler. A 32-bit Galois
// LFSR is reseeded from the key at the start of each field's active video
// and advanced eight steps per active line; the top byte becomes the cut
// position for that line.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the next active-line h_rise, cut_position held
// STEP  | advancing the LFSR one step per cycle, eight steps per line
module cut_position_keygen #(
    parameter logic [31:0] DEFAULT_SEED = 32'h0000_002A,
    parameter logic [31:0] TAPS         = 32'h8020_0003,
    parameter logic [31:0] FIELD_MASK   = 32'hA5A5_A5A5
) (
    input  logic                 clk,
    input  logic                 reset,
    cut_position_keygen_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        h_d;
    logic        v_d;
    logic        h_rise;
    logic        v_fall;
    logic [31:0] key_reg;
    logic [31:0] lfsr;
    logic [31:0] next_lfsr;
    logic [31:0] field_key;
    logic [31:0] reseed_val;
    logic [2:0]  cnt;
    logic        do_step;
    logic        step_done;
    logic        busy_c;
    logic [7:0]  cut_position_r;
    logic        cut_valid_r;

    assign h_rise = bus.H & ~h_d;
    assign v_fall = ~bus.V & v_d;

    assign next_lfsr  = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);
    assign field_key  = key_reg ^ (bus.F ? FIELD_MASK : 32'h0);
    // An all-zero LFSR would lock up, so substitute the default seed.
    assign reseed_val = (field_key == 32'h0) ? DEFAULT_SEED : field_key;

    // Previous-cycle H/V for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_d <= 1'b0;
            v_d <= 1'b0;
        end else begin
            h_d <= bus.H;
            v_d <= bus.V;
        end
    end

    // Key capture; it only reaches the LFSR at the next field start.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_reg <= DEFAULT_SEED;
        end else if (bus.seed_load) begin
            key_reg <= (bus.seed_in == 32'h0) ? DEFAULT_SEED : bus.seed_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; a field start aborts a line in progress.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (h_rise && !bus.V) state_nxt = STEP;
            STEP: if (v_fall || cnt == 3'd7) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: step enable, last-step flag and busy.
    always_comb begin
        do_step   = (state == STEP) && !v_fall;
        step_done = do_step && (cnt == 3'd7);
        busy_c    = (state == STEP);
    end

    // LFSR: reseed has priority over stepping.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= DEFAULT_SEED;
        end else if (v_fall) begin
            lfsr <= reseed_val;
        end else if (do_step) begin
            lfsr <= next_lfsr;
        end
    end

    // Step counter, cleared whenever no step is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (do_step) begin
            cnt <= cnt + 3'd1;
        end else begin
            cnt <= 3'd0;
        end
    end

    // Publish the cut position after the eighth step of a line.
    always_ff @(posedge clk) begin
        if (reset) begin
            cut_position_r <= 8'h00;
            cut_valid_r    <= 1'b0;
        end else begin
            cut_valid_r <= step_done;
            if (step_done) begin
                cut_position_r <= next_lfsr[31:24];
            end
        end
    end

    assign bus.cut_position = cut_position_r;
    assign bus.cut_valid    = cut_valid_r;
    assign bus.busy         = busy_c;

endmodule

// File: tb/tb_cut_position_keygen.sv
// Directed bench for cut_position_keygen with a behavioural LFSR model and
// a scoreboard of expected cut positions.
module tb_cut_position_keygen;

    localparam logic [31:0] DEF  = 32'h0000_002A;
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam logic [31:0] FMSK = 32'hA5A5_A5A5;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [7:0]  exp_q[$];
    logic [31:0] m_key;
    logic [31:0] m_lfsr;
    logic [7:0]  got;
    logic [7:0]  hold;
    logic [7:0]  rec[10];

    cut_position_keygen_if bus();

    cut_position_keygen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] m_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] m_reseed(input logic [31:0] k, input logic f);
        logic [31:0] v;
        v = k ^ (f ? FMSK : 32'h0);
        return (v == 32'h0) ? DEF : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every cut_valid must match the oldest expected value.
    always @(negedge clk) begin
        if (bus.cut_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=%h expected=none", bus.cut_position);
            end
            if (exp_q.size() != 0) check("cut_sb", {24'h0, bus.cut_position}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic push_line();
        for (int i = 0; i < 8; i++) m_lfsr = m_step(m_lfsr);
        exp_q.push_back(m_lfsr[31:24]);
    endtask

    // Entered at the start of cycle T with the rising H already applied.
    task automatic run_line(output logic [7:0] cut);
        tick();
        bus.H = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("busy_step", {31'h0, bus.busy}, 32'd1);
            check("valid_low", {31'h0, bus.cut_valid}, 32'd0);
            tick();
        end
        check("busy_done", {31'h0, bus.busy}, 32'd0);
        check("valid_pulse", {31'h0, bus.cut_valid}, 32'd1);
        cut = bus.cut_position;
        tick();
        check("valid_one", {31'h0, bus.cut_valid}, 32'd0);
        tick();
    endtask

    task automatic do_line(output logic [7:0] cut);
        bus.H = 1'b1;
        push_line();
        run_line(cut);
    endtask

    task automatic start_field(input logic f);
        bus.H = 1'b0;
        bus.V = 1'b1;
        repeat (4) tick();
        bus.V = 1'b0;
        bus.F = f;
        m_lfsr = m_reseed(m_key, f);
        tick();
        check("reseed", dut.lfsr, m_lfsr);
        tick();
    endtask

    task automatic load_key(input logic [31:0] k);
        bus.seed_in   = k;
        bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        m_key = (k == 32'h0) ? DEF : k;
    endtask

    initial begin
        bus.H = 1'b0; bus.V = 1'b1; bus.F = 1'b0;
        bus.seed_in = 32'h0; bus.seed_load = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m_key = DEF; m_lfsr = DEF;

        // Reset state held through vertical blanking.
        repeat (3) begin
            tick();
            check("rst_cut", {24'h0, bus.cut_position}, 32'h0);
            check("rst_valid", {31'h0, bus.cut_valid}, 32'd0);
            check("rst_busy", {31'h0, bus.busy}, 32'd0);
        end
        // h_rise while V=1 is ignored.
        bus.H = 1'b1; tick();
        check("vblank_busy", {31'h0, bus.busy}, 32'd0);
        bus.H = 1'b0; repeat (12) tick();
        check("vblank_cut", {24'h0, bus.cut_position}, 32'h0);

        // Default key, F=0: first line gives 0x0E.
        start_field(1'b0);
        do_line(got);
        check("lfsr_8steps", dut.lfsr, 32'h0E03_8000);
        check("first_cut", {24'h0, got}, 32'h0E);
        repeat (9) do_line(got);

        // F=1 field, then the same field again must repeat.
        start_field(1'b1);
        for (int i = 0; i < 10; i++) do_line(rec[i]);
        checks++;
        assert (rec[0] !== 8'h0E) else begin
            errors++;
            $error("FAIL f1_differs observed=%h expected=not 0e", rec[0]);
        end
        start_field(1'b1);
        for (int i = 0; i < 10; i++) begin
            do_line(got);
            check("f1_repeat", {24'h0, got}, {24'h0, rec[i]});
        end

        // New key takes effect at field start; zero load mid-field is deferred.
        load_key(32'h1234_5678);
        start_field(1'b0);
        repeat (3) do_line(got);
        load_key(32'h0);
        repeat (3) do_line(got);
        start_field(1'b0);
        do_line(got);
        check("zero_key_next", {24'h0, got}, 32'h0E);

        // Key that cancels the field mask reseeds with the default seed.
        load_key(FMSK);
        start_field(1'b1);
        check("zero_reseed", dut.lfsr, DEF);
        do_line(got);
        load_key(32'h0);

        // V rises and falls mid-line: abort, reseed, hold cut_position.
        hold = bus.cut_position;
        bus.H = 1'b1; tick();
        bus.H = 1'b0; tick(); tick();
        bus.V = 1'b1; tick();
        check("vrise_busy", {31'h0, bus.busy}, 32'd1);
        bus.V = 1'b0; bus.F = 1'b0;
        m_lfsr = m_reseed(m_key, 1'b0);
        tick();
        check("abort_busy", {31'h0, bus.busy}, 32'd0);
        check("abort_lfsr", dut.lfsr, m_lfsr);
        repeat (10) tick();
        check("abort_hold", {24'h0, bus.cut_position}, {24'h0, hold});

        // v_fall and h_rise in the same cycle.
        bus.V = 1'b1; repeat (3) tick();
        bus.V = 1'b0; bus.H = 1'b1; bus.F = 1'b0;
        m_lfsr = m_reseed(m_key, 1'b0);
        push_line();
        run_line(got);
        check("simul_cut", {24'h0, got}, 32'h0E);

        // Reset mid-line; H held high counts as h_rise right after reset.
        bus.H = 1'b1; tick(); tick(); tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        check("mrst_busy", {31'h0, bus.busy}, 32'd0);
        check("mrst_cut", {24'h0, bus.cut_position}, 32'h0);
        check("mrst_lfsr", dut.lfsr, DEF);
        m_key = DEF; m_lfsr = DEF;
        push_line();
        run_line(got);
        check("post_rst_cut", {24'h0, got}, 32'h0E);

        repeat (20) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
